// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, FSM state type and boot image for the instruction memory responder.
// The boot image is only used when IMEM_BOOT_PROG_EN is defined.
package imem_pkg;
    localparam logic [31:0] NOP = 32'h0000_0033;
    localparam int DEPTH_WORDS_DEF = 4096;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Counts x1 up to x2 with a backward bne, then parks on a self-jump.
    function automatic logic [31:0] boot_word(input int i);
        case (i)
            0: return 32'h0000_0093;
            1: return 32'h0080_0113;
            2: return 32'h0010_8093;
            3: return 32'hFE20_9EE3;
            4: return 32'h0010_0193;
            5: return 32'h0000_006F;
            default: return NOP;
        endcase
    endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction word storage with one registered read port and one write port.
// With IMEM_BOOT_PROG_EN defined the storage starts out holding the boot image.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);
`ifdef IMEM_BOOT_PROG_EN
    typedef logic [31:0] mem_t [DEPTH_WORDS];

    function automatic mem_t boot_image();
        for (int i = 0; i < DEPTH_WORDS; i++) boot_image[i] = boot_word(i);
    endfunction

    mem_t mem = boot_image();
`else
    logic [31:0] mem [DEPTH_WORDS];
`endif

    always_ff @(posedge clk)
        if (wr_en) mem[wr_idx] <= wr_data;

    // Only the read register is reset; stored words survive reset.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_data <= NOP;
        else if (rd_en) rd_data <= mem[rd_idx];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with valid/ready handshakes and flush.
// Build option IMEM_BOOT_PROG_EN preloads the storage with a boot program.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic [63:0] i_req_addr,
    output logic        o_req_ready,
    input  logic        i_flush,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_instr,
    output logic [63:0] o_rsp_addr,
    output logic        o_rsp_err,
    input  logic        i_wr_en,
    input  logic [63:0] i_wr_addr,
    input  logic [31:0] i_wr_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) << 2;
    localparam logic [2:0] LAST = 3'(LATENCY - 1);
    localparam state_t FIRST = (LATENCY == 1) ? RESP : WAIT;

    state_t      state;
    logic [2:0]  cnt;
    logic        err;
    logic        accept;
    logic        wr_ok;
    logic [31:0] rd_data;

    assign o_req_ready = i_rst_n && !i_flush && (state == IDLE || (state == RESP && i_rsp_ready));
    assign accept      = i_req_valid && o_req_ready;
    assign wr_ok       = i_wr_en && i_wr_addr[1:0] == 2'b00 && i_wr_addr < LIMIT;
    assign o_rsp_valid = state == RESP;
    assign o_rsp_err   = err;
    assign o_rsp_instr = err ? NOP : rd_data;

    imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .rd_en   (accept),
        .rd_idx  (i_req_addr[2+:AW]),
        .rd_data (rd_data),
        .wr_en   (wr_ok),
        .wr_idx  (i_wr_addr[2+:AW]),
        .wr_data (i_wr_data)
    );

    // A same-cycle accept in RESP restarts the pipeline instead of returning to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            err        <= 1'b0;
            o_rsp_addr <= '0;
        end else if (i_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state      <= FIRST;
            cnt        <= 3'(LATENCY > 1);
            o_rsp_addr <= i_req_addr;
            err        <= i_req_addr[1:0] != 2'b00 || i_req_addr >= LIMIT;
        end else if (state == WAIT) begin
            state <= cnt == LAST ? RESP : WAIT;
            cnt   <= cnt == LAST ? 3'd0 : cnt + 3'd1;
        end else if (state == RESP && i_rsp_ready) begin
            state <= IDLE;
        end
endmodule
